prbs31_burst_ctrl: RTL and testbench
====================================

// Module: prbs31_burst_ctrl
// PURPOSE
//   Sequencer for the PRBS31 generator/checker datapath. On a start request it
//   seeds the external PRBS31 core, then runs one burst of cfg_len bits:
//   - Generate mode: drives the bits out.
//   - Check mode: compares the bits against received data and counts errors.
//   Sits between the user-IO config/control pins and the PRBS31 core.
// PARAMETERS
//   LEN_W  16  width of burst-length counter/config (max burst 2^LEN_W-1 bits)
//   ERR_W  16  width of error counter (saturating)
// PORTS
//   clk          in   1      clock
//   rst_n        in   1      async reset, active low
//   start        in   1      start request; accepted only in IDLE
//   abort        in   1      abandon burst, return to IDLE
//   cfg_check    in   1      0=generate, 1=check; captured on start accept
//   cfg_len      in   LEN_W  burst length in bits; captured on start accept
//   cfg_seed     in   31     LFSR seed; captured on start accept
//   prbs_load    out  1      1-cycle pulse: core loads prbs_seed
//   prbs_seed    out  31     captured seed, stable while busy
//   prbs_step    out  1      core advances one bit this cycle
//   prbs_bit     in   1      current core output bit (valid same cycle)
//   rx_valid     in   1      received bit valid (check mode)
//   rx_bit       in   1      received bit
//   err_inject   in   1      invert next transmitted bit (see CONFIGURATION)
//   tx_valid     out  1      tx_bit valid (generate mode)
//   tx_bit       out  1      transmitted bit
//   busy         out  1      high in LOAD and RUN
//   done         out  1      1-cycle pulse on burst completion
//   err_cnt      out  ERR_W  mismatch count of current/last burst
//   err_sat      out  1      err_cnt has saturated
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0, incl. prbs_seed, err_cnt, err_sat.
//   FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 (and abort=0) -> capture cfg_*, clear err_cnt/err_sat,
//     bit counter=0, go to LOAD.
//   - LOAD: prbs_load=1 for exactly one cycle.
//     cfg_len==0 -> DONE (no steps); otherwise -> RUN.
//   - RUN, generate mode: every cycle tx_valid=1, tx_bit=prbs_bit,
//     prbs_step=1, counter+1. The first tx bit appears the cycle after
//     prbs_load.
//   - RUN, check mode: prbs_step=rx_valid. On rx_valid, compare rx_bit with
//     prbs_bit; on mismatch err_cnt+1, saturating at all-ones (then
//     err_sat=1 sticky until next start). Counter+1 per rx_valid. rx_valid
//     outside RUN is ignored.
//   - RUN exit: the cycle the counter reaches cfg_len (the last bit is
//     stepped that cycle) -> DONE.
//   - DONE: done=1 for one cycle, busy=0 -> IDLE. err_cnt holds until the
//     next accepted start.
//   Control rules:
//   - start while busy: ignored.
//   - abort: from any state -> IDLE next cycle. No done pulse, prbs_step=0
//     that cycle, err_cnt retained. abort wins over simultaneous start.
//   - tx_valid and prbs_step are 0 outside RUN.
//   - Async reset mid-burst: immediate return to reset values.
// CONFIGURATION
//   PRBS31_ERR_INJECT_EN defined:
//   - err_inject=1 in any state arms a one-shot flag. The next generate-mode
//     tx bit is inverted, then the flag clears.
//   - Flag is cleared on start accept and on abort. No effect in check mode.
//   Not defined: err_inject is ignored and tx_bit=prbs_bit always. The port
//   is present in both builds.
// TESTING
//   1. Gen, cfg_len=8: start -> prbs_load at T+1, tx_valid T+2..T+9, 8 steps,
//      done at T+10.
//   2. Check, cfg_len=31, rx from a matching reference LFSR with gapped
//      rx_valid -> done, err_cnt=0.
//   3. Check, 3 flipped rx bits of 100 -> err_cnt=3.
//      With ERR_W=2 and 5 flips -> err_cnt=3, err_sat=1.
//   4. cfg_len=0 -> prbs_load, done two cycles after start, no steps.
//   5. abort in RUN at bit 5 -> IDLE next cycle, no done, err_cnt held.
//      start during RUN ignored.
//   6. With PRBS31_ERR_INJECT_EN, err_inject mid-burst -> exactly one
//      inverted tx bit; without the macro -> none.

Source files
------------

// File: rtl/prbs31_burst_ctrl_if.sv
// Control, configuration and PRBS31 core signals of prbs31_burst_ctrl.
// The controller takes the slave view; the user side and the PRBS core model take the master view.
interface prbs31_burst_ctrl_if #(
    parameter int LEN_W = 16,
    parameter int ERR_W = 16
);
    logic             start;
    logic             abort;
    logic             cfg_check;
    logic [LEN_W-1:0] cfg_len;
    logic [30:0]      cfg_seed;
    logic             prbs_load;
    logic [30:0]      prbs_seed;
    logic             prbs_step;
    logic             prbs_bit;
    logic             rx_valid;
    logic             rx_bit;
    logic             err_inject;
    logic             tx_valid;
    logic             tx_bit;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;
    logic             err_sat;

    modport master (
        output start, abort, cfg_check, cfg_len, cfg_seed,
        output prbs_bit, rx_valid, rx_bit, err_inject,
        input  prbs_load, prbs_seed, prbs_step,
        input  tx_valid, tx_bit, busy, done, err_cnt, err_sat
    );

    modport slave (
        input  start, abort, cfg_check, cfg_len, cfg_seed,
        input  prbs_bit, rx_valid, rx_bit, err_inject,
        output prbs_load, prbs_seed, prbs_step,
        output tx_valid, tx_bit, busy, done, err_cnt, err_sat
    );
endinterface

// File: rtl/prbs31_burst_ctrl.sv
// Burst sequencer for an external PRBS31 core: seeds it, then generates or checks cfg_len bits.
// Optional build macro PRBS31_ERR_INJECT_EN enables one-shot inversion of the next transmitted bit.
module prbs31_burst_ctrl #(
    parameter int LEN_W = 16,
    parameter int ERR_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    prbs31_burst_ctrl_if.slave ctrl_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             check_q, check_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [30:0]      seed_q, seed_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             sat_q, sat_d;

    logic             start_acc;
    logic             step;
    logic             tx_fire;
    logic             inj_active;
    logic [LEN_W-1:0] cnt_inc;
    logic [ERR_W-1:0] err_inc;

    assign cnt_inc = cnt_q + 1'b1;
    assign err_inc = err_q + 1'b1;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        check_d   = check_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        seed_d    = seed_q;
        err_d     = err_q;
        sat_d     = sat_q;
        start_acc = 1'b0;
        step      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_if.start && !ctrl_if.abort) begin
                    start_acc = 1'b1;
                    check_d   = ctrl_if.cfg_check;
                    len_d     = ctrl_if.cfg_len;
                    seed_d    = ctrl_if.cfg_seed;
                    cnt_d     = '0;
                    err_d     = '0;
                    sat_d     = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (len_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                // An aborted cycle must neither step the core nor touch the error count.
                step = !ctrl_if.abort && (!check_q || ctrl_if.rx_valid);
                if (step) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DONE;
                    end
                    if (check_q && (ctrl_if.rx_bit != ctrl_if.prbs_bit) && (err_q != '1)) begin
                        err_d = err_inc;
                        if (err_inc == '1) begin
                            sat_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ctrl_if.abort) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            check_q <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            check_q <= check_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
        end
    end

    assign tx_fire = step && !check_q;

`ifdef PRBS31_ERR_INJECT_EN
    logic inj_q, inj_d;

    // Arm wins over consumption in the same cycle; start accept and abort clear it outright.
    always_comb begin
        inj_d = inj_q;
        if (tx_fire) begin
            inj_d = 1'b0;
        end
        if (ctrl_if.err_inject) begin
            inj_d = 1'b1;
        end
        if (start_acc || ctrl_if.abort) begin
            inj_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end

    assign inj_active = inj_q;
`else
    logic unused_err_inject;
    logic unused_start_acc;

    assign unused_err_inject = ctrl_if.err_inject;
    assign unused_start_acc  = start_acc;
    assign inj_active        = 1'b0;
`endif

    assign ctrl_if.prbs_load = (state_q == S_LOAD);
    assign ctrl_if.prbs_seed = seed_q;
    assign ctrl_if.prbs_step = step;
    assign ctrl_if.tx_valid  = tx_fire;
    assign ctrl_if.tx_bit    = tx_fire & (ctrl_if.prbs_bit ^ inj_active);
    assign ctrl_if.busy      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign ctrl_if.done      = (state_q == S_DONE) && !ctrl_if.abort;
    assign ctrl_if.err_cnt   = err_q;
    assign ctrl_if.err_sat   = sat_q;

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// Directed bench for prbs31_burst_ctrl: two instances (ERR_W=16 and ERR_W=2) share stimulus,
// each with its own PRBS31 core model (x^31 + x^28 + 1, output = bit 30).
module tb_prbs31_burst_ctrl;

    localparam logic [30:0] SEED = 31'h2A3C_5E71;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        start, abort, cfg_check, rx_valid, rx_bit, err_inject;
    logic [15:0] cfg_len;
    logic [30:0] cfg_seed;

    prbs31_burst_ctrl_if #(.LEN_W(16), .ERR_W(16)) bus_a ();
    prbs31_burst_ctrl_if #(.LEN_W(16), .ERR_W(2))  bus_b ();

    assign bus_a.start      = start;
    assign bus_a.abort      = abort;
    assign bus_a.cfg_check  = cfg_check;
    assign bus_a.cfg_len    = cfg_len;
    assign bus_a.cfg_seed   = cfg_seed;
    assign bus_a.rx_valid   = rx_valid;
    assign bus_a.rx_bit     = rx_bit;
    assign bus_a.err_inject = err_inject;
    assign bus_b.start      = start;
    assign bus_b.abort      = abort;
    assign bus_b.cfg_check  = cfg_check;
    assign bus_b.cfg_len    = cfg_len;
    assign bus_b.cfg_seed   = cfg_seed;
    assign bus_b.rx_valid   = rx_valid;
    assign bus_b.rx_bit     = rx_bit;
    assign bus_b.err_inject = err_inject;

    logic [30:0] lfsr_a, lfsr_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_a <= '0;
        else if (bus_a.prbs_load) lfsr_a <= bus_a.prbs_seed;
        else if (bus_a.prbs_step) lfsr_a <= {lfsr_a[29:0], lfsr_a[30] ^ lfsr_a[27]};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_b <= '0;
        else if (bus_b.prbs_load) lfsr_b <= bus_b.prbs_seed;
        else if (bus_b.prbs_step) lfsr_b <= {lfsr_b[29:0], lfsr_b[30] ^ lfsr_b[27]};
    end

    assign bus_a.prbs_bit = lfsr_a[30];
    assign bus_b.prbs_bit = lfsr_b[30];

    prbs31_burst_ctrl #(.LEN_W(16), .ERR_W(16)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus_a.slave)
    );

    prbs31_burst_ctrl #(.LEN_W(16), .ERR_W(2)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus_b.slave)
    );

    function automatic logic ref_bit(input logic [30:0] seed, input int idx);
        logic [30:0] l;
        l = seed;
        for (int i = 0; i < idx; i++) l = {l[29:0], l[30] ^ l[27]};
        return l[30];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        abort      = 1'b0;
        rx_valid   = 1'b0;
        rx_bit     = 1'b0;
        err_inject = 1'b0;
    endtask

    task automatic test_reset();
        logic [56:0] got;
        cfg_seed = SEED;
        #1;
        got = {bus_a.prbs_load, bus_a.prbs_seed, bus_a.prbs_step, bus_a.tx_valid, bus_a.tx_bit,
               bus_a.busy, bus_a.done, bus_a.err_cnt, bus_a.err_sat};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got = {bus_a.prbs_load, bus_a.prbs_seed, bus_a.prbs_step, bus_a.tx_valid, bus_a.tx_bit,
               bus_a.busy, bus_a.done, bus_a.err_cnt, bus_a.err_sat};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got %h exp 0", got);
        end
    endtask

    task automatic test_gen_basic();
        logic [4:0] got, exp;
        int steps;
        steps     = 0;
        cfg_check = 1'b0;
        cfg_len   = 16'd8;
        cfg_seed  = SEED;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int w = 1; w <= 11; w++) begin
            got = {bus_a.prbs_load, bus_a.tx_valid, bus_a.tx_bit, bus_a.done, bus_a.busy};
            exp = {w == 1, (w >= 2 && w <= 9), (w >= 2 && w <= 9) ? ref_bit(SEED, w - 2) : 1'b0,
                   w == 10, (w >= 1 && w <= 9)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL gen_w%0d load/txv/txb/done/busy got %b exp %b", w, got, exp);
            end
            if (w == 5) begin
                checks++;
                if (bus_a.prbs_seed !== SEED) begin
                    errors++;
                    $display("FAIL gen_seed got %h exp %h", bus_a.prbs_seed, SEED);
                end
            end
            if (bus_a.prbs_step) steps++;
            tick();
        end
        checks++;
        if (steps != 8) begin
            errors++;
            $display("FAIL gen_steps got %0d exp 8", steps);
        end
    endtask

    task automatic run_check(input int len, input bit gapped, input logic [127:0] flips,
                             output int steps, output bit done_seen);
        int idx;
        bit v;
        steps     = 0;
        done_seen = 1'b0;
        idx       = 0;
        cfg_check = 1'b1;
        cfg_len   = 16'(len);
        cfg_seed  = SEED;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        rx_valid  = 1'b1;
        rx_bit    = ~ref_bit(SEED, 0);
        #1;
        checks++;
        if (bus_a.prbs_step !== 1'b0 || bus_a.err_cnt !== '0) begin
            errors++;
            $display("FAIL chk_load_rx_ignored step %b cnt %0d exp 0 0", bus_a.prbs_step, bus_a.err_cnt);
        end
        tick();
        for (int w = 2; w < 400 && !done_seen; w++) begin
            v        = gapped ? (w % 3 != 0) : 1'b1;
            rx_valid = v;
            rx_bit   = v ? (ref_bit(SEED, idx) ^ flips[idx]) : 1'b0;
            #1;
            if (bus_a.prbs_step) begin
                steps++;
                idx++;
            end
            if (bus_a.done) done_seen = 1'b1;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_check_gapped();
        int steps;
        bit done_seen;
        run_check(31, 1'b1, '0, steps, done_seen);
        checks++;
        if (!done_seen || steps != 31) begin
            errors++;
            $display("FAIL chk_gapped done %b steps %0d exp 1 31", done_seen, steps);
        end
        checks++;
        if (bus_a.err_cnt !== 16'd0 || bus_a.err_sat !== 1'b0) begin
            errors++;
            $display("FAIL chk_gapped_err cnt %0d sat %b exp 0 0", bus_a.err_cnt, bus_a.err_sat);
        end
    endtask

    task automatic test_check_errors();
        int steps;
        bit done_seen;
        logic [127:0] flips;
        flips = '0;
        flips[10] = 1'b1;
        flips[50] = 1'b1;
        flips[99] = 1'b1;
        run_check(100, 1'b0, flips, steps, done_seen);
        checks++;
        if (!done_seen || steps != 100) begin
            errors++;
            $display("FAIL chk3_done done %b steps %0d exp 1 100", done_seen, steps);
        end
        checks++;
        if (bus_a.err_cnt !== 16'd3 || bus_a.err_sat !== 1'b0) begin
            errors++;
            $display("FAIL chk3_err cnt %0d sat %b exp 3 0", bus_a.err_cnt, bus_a.err_sat);
        end
        flips = '0;
        flips[3]  = 1'b1;
        flips[20] = 1'b1;
        flips[40] = 1'b1;
        flips[60] = 1'b1;
        flips[80] = 1'b1;
        run_check(100, 1'b1, flips, steps, done_seen);
        checks++;
        if (bus_a.err_cnt !== 16'd5 || bus_a.err_sat !== 1'b0) begin
            errors++;
            $display("FAIL chk5_wide cnt %0d sat %b exp 5 0", bus_a.err_cnt, bus_a.err_sat);
        end
        checks++;
        if (bus_b.err_cnt !== 2'd3 || bus_b.err_sat !== 1'b1) begin
            errors++;
            $display("FAIL chk5_sat cnt %0d sat %b exp 3 1", bus_b.err_cnt, bus_b.err_sat);
        end
        repeat (3) tick();
        checks++;
        if (bus_a.err_cnt !== 16'd5 || bus_b.err_sat !== 1'b1) begin
            errors++;
            $display("FAIL chk5_hold cnt %0d sat %b exp 5 1", bus_a.err_cnt, bus_b.err_sat);
        end
    endtask

    task automatic test_len_zero();
        logic [3:0] got, exp;
        cfg_check = 1'b0;
        cfg_len   = 16'd0;
        cfg_seed  = SEED;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            got = {bus_a.prbs_load, bus_a.prbs_step | bus_a.tx_valid, bus_a.done, bus_a.busy};
            exp = {w == 1, 1'b0, w == 2, w == 1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL len0_w%0d load/step/done/busy got %b exp %b", w, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        bit bad;
        cfg_check = 1'b1;
        cfg_len   = 16'd20;
        cfg_seed  = SEED;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_bit   = ~ref_bit(SEED, i);
            start    = (i == 0);
            cfg_len  = (i == 0) ? 16'd2 : 16'd20;
            tick();
            if (i == 0) begin
                checks++;
                if (bus_a.prbs_load !== 1'b0 || bus_a.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL start_in_run load %b busy %b exp 0 1", bus_a.prbs_load, bus_a.busy);
                end
            end
        end
        start    = 1'b0;
        abort    = 1'b1;
        rx_valid = 1'b1;
        rx_bit   = ~ref_bit(SEED, 5);
        #1;
        checks++;
        if (bus_a.prbs_step !== 1'b0 || bus_a.err_cnt !== 16'd5) begin
            errors++;
            $display("FAIL abort_cycle step %b cnt %0d exp 0 5", bus_a.prbs_step, bus_a.err_cnt);
        end
        tick();
        idle_inputs();
        bad = 1'b0;
        for (int w = 0; w < 4; w++) begin
            #1;
            if (bus_a.busy || bus_a.done || bus_a.prbs_load) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || bus_a.err_cnt !== 16'd5) begin
            errors++;
            $display("FAIL abort_idle activity %b cnt %0d exp 0 5", bad, bus_a.err_cnt);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.prbs_load !== 1'b0 || bus_a.err_cnt !== 16'd5) begin
            errors++;
            $display("FAIL abort_wins busy %b load %b cnt %0d exp 0 0 5",
                     bus_a.busy, bus_a.prbs_load, bus_a.err_cnt);
        end
    endtask

    task automatic test_err_inject();
        int txs, flips, flip_idx, exp_flips, exp_idx;
`ifdef PRBS31_ERR_INJECT_EN
        exp_flips = 1;
        exp_idx   = 4;
`else
        exp_flips = 0;
        exp_idx   = -1;
`endif
        txs       = 0;
        flips     = 0;
        flip_idx  = -1;
        cfg_check = 1'b0;
        cfg_len   = 16'd16;
        cfg_seed  = SEED;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int w = 1; w <= 18; w++) begin
            err_inject = (w == 5);
            #1;
            if (bus_a.tx_valid) begin
                if (bus_a.tx_bit !== ref_bit(SEED, w - 2)) begin
                    flips++;
                    flip_idx = w - 2;
                end
                txs++;
            end
            tick();
        end
        err_inject = 1'b0;
        checks++;
        if (txs != 16 || flips != exp_flips || flip_idx != exp_idx) begin
            errors++;
            $display("FAIL inject txs %0d flips %0d at %0d exp 16 %0d at %0d",
                     txs, flips, flip_idx, exp_flips, exp_idx);
        end
    endtask

    task automatic test_async_reset();
        cfg_check = 1'b0;
        cfg_len   = 16'd50;
        cfg_seed  = SEED;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_a.tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre txv got %b exp 1", bus_a.tx_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.busy, bus_a.tx_valid, bus_a.prbs_step, bus_a.prbs_seed} !== '0) begin
            errors++;
            $display("FAIL arst_mid busy %b txv %b step %b seed %h exp all 0",
                     bus_a.busy, bus_a.tx_valid, bus_a.prbs_step, bus_a.prbs_seed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            errors++;
            $display("FAIL arst_after busy %b done %b exp 0 0", bus_a.busy, bus_a.done);
        end
    endtask

    initial begin
        idle_inputs();
        cfg_check = 1'b0;
        cfg_len   = '0;
        cfg_seed  = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_gen_basic();
        test_check_gapped();
        test_check_errors();
        test_len_zero();
        test_abort();
        test_err_inject();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
